// File: rtl/sno_integrator_seq.sv
// Multi-channel charge integrator sequencer.
// A trigger starts a fixed-length integration window. Per-channel samples are
// summed into saturating accumulators. The high/low-gain charge words and their
// channel sums are latched for readout over a valid/ready handshake. The
// accumulators are then discharged for a fixed number of clocks.
module sno_integrator_seq #(
    parameter int NCH      = 4,
    parameter int W_IN     = 8,
    parameter int W_ACC    = 16,
    parameter int INT_CYC  = 16,
    parameter int DMP_CYC  = 4,
    parameter int LO_SHIFT = 3
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            TRIG,
    input  logic [NCH-1:0]                  CH_EN,
    input  logic [NCH*W_IN-1:0]             SAMPLE,
    output logic [NCH*W_ACC-1:0]            Q_HI,
    output logic [NCH*W_ACC-1:0]            Q_LO,
    output logic [W_ACC+$clog2(NCH)-1:0]    OUTSUM_HI,
    output logic [W_ACC+$clog2(NCH)-1:0]    OUTSUM_LO,
    output logic                            DATA_VALID,
    input  logic                            DATA_READY,
    output logic                            BUSY,
    output logic                            DUMP,
    output logic [NCH-1:0]                  SAT,
    output logic [7:0]                      MISS_CNT
);

    localparam int W_OS    = W_ACC + $clog2(NCH);
    localparam int W_SUM   = ((W_IN > W_ACC) ? W_IN : W_ACC) + 1;
    localparam int CNT_MAX = (INT_CYC > DMP_CYC) ? INT_CYC : DMP_CYC;
    localparam int W_CNT   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INTEG = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DMP   = 2'd3;

    logic [1:0]       state;
    logic [W_CNT-1:0] cnt;
    logic [W_ACC-1:0] acc     [NCH];
    logic [W_ACC-1:0] acc_add [NCH];
    logic [NCH-1:0]   ovf;
    logic [W_OS-1:0]  sum_hi;
    logic [W_OS-1:0]  sum_lo;
    logic [W_IN-1:0]  samp;
    logic [W_SUM-1:0] wide;

    // Saturating per-channel add of this clock's sample; sums feed the HOLD load
    // so the final add of the window is already included when results latch.
    always_comb begin
        ovf    = '0;
        sum_hi = '0;
        sum_lo = '0;
        samp   = '0;
        wide   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            samp = '0;
            if (CH_EN[i]) samp = SAMPLE[i*W_IN +: W_IN];
            wide = W_SUM'(acc[i]) + W_SUM'(samp);
            acc_add[i] = wide[W_ACC-1:0];
            if (wide[W_SUM-1:W_ACC] != '0) begin
                acc_add[i] = '1;
                ovf[i]     = 1'b1;
            end
            sum_hi = sum_hi + W_OS'(acc_add[i]);
            sum_lo = sum_lo + W_OS'(acc_add[i] >> LO_SHIFT);
        end
    end

    // Sequencer: IDLE -> INTEG -> HOLD -> DMP -> IDLE, with accumulators and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cnt       <= '0;
            Q_HI      <= '0;
            Q_LO      <= '0;
            OUTSUM_HI <= '0;
            OUTSUM_LO <= '0;
            SAT       <= '0;
            for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (TRIG) begin
                        state <= S_INTEG;
                        cnt   <= '0;
                        SAT   <= '0;
                        for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
                    end
                end
                S_INTEG: begin
                    for (int unsigned i = 0; i < NCH; i++) acc[i] <= acc_add[i];
                    SAT <= SAT | ovf;
                    if (cnt == W_CNT'(INT_CYC - 1)) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                        for (int unsigned i = 0; i < NCH; i++) begin
                            Q_HI[i*W_ACC +: W_ACC] <= acc_add[i];
                            Q_LO[i*W_ACC +: W_ACC] <= acc_add[i] >> LO_SHIFT;
                        end
                        OUTSUM_HI <= sum_hi;
                        OUTSUM_LO <= sum_lo;
                    end else begin
                        cnt <= cnt + W_CNT'(1);
                    end
                end
                S_HOLD: begin
                    if (DATA_READY) begin
                        state <= S_DMP;
                        cnt   <= '0;
                    end
                end
                S_DMP: begin
                    for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
                    if (cnt == W_CNT'(DMP_CYC - 1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + W_CNT'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of triggers seen while a cycle is already in progress.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MISS_CNT <= '0;
        end else if (TRIG && (state != S_IDLE) && (MISS_CNT != 8'hFF)) begin
            MISS_CNT <= MISS_CNT + 8'd1;
        end
    end

    // Status flags decoded from the current phase.
    always_comb begin
        DATA_VALID = (state == S_HOLD);
        BUSY       = (state != S_IDLE);
        DUMP       = (state == S_DMP);
    end

endmodule
